// File: rtl/fp_unit_sched.sv
// Shares one multicycle FP_Unit datapath between two valid/ready requesters.
// Round-robin grant, operands held for an op-dependent latency, result returned tagged with requester id.
module fp_unit_sched #(
   parameter int DATA_WIDTH = 32,
   parameter int ARITH_LAT  = 2,
   parameter int DIV_LAT    = 8
) (
   input  logic                      in_clk,
   input  logic                      in_rst,
   input  logic [1:0]                in_req_valid,
   output logic [1:0]                out_req_ready,
   input  logic [7:0]                in_req_op,
   input  logic [3:0]                in_req_fmt,
   input  logic [1:0]                in_req_addsub,
   input  logic [5:0]                in_req_ctrl,
   input  logic [2*DATA_WIDTH-1:0]   in_req_rs1,
   input  logic [2*DATA_WIDTH-1:0]   in_req_rs2,
   output logic [3:0]                out_fpu_op,
   output logic [1:0]                out_fpu_fmt,
   output logic                      out_fpu_addsub,
   output logic [2:0]                out_fpu_ctrl,
   output logic [DATA_WIDTH-1:0]     out_fpu_rs1,
   output logic [DATA_WIDTH-1:0]     out_fpu_rs2,
   input  logic [DATA_WIDTH-1:0]     in_fpu_result,
   output logic                      out_rsp_valid,
   input  logic                      in_rsp_ready,
   output logic                      out_rsp_id,
   output logic [DATA_WIDTH-1:0]     out_rsp_data
);

   localparam int MAX_LAT = (ARITH_LAT > DIV_LAT) ? ARITH_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]            state;
   logic [CNT_W-1:0]      cnt;
   logic                  rr_last;
   logic                  grant;
   logic                  accept;
   logic [3:0]            sel_op;
   logic [CNT_W-1:0]      load_cnt;

   // On a tie the requester not granted last wins; a lone requester always wins.
   always_comb begin
      grant = 1'b0;
      if (in_req_valid == 2'b10) begin
         grant = 1'b1;
      end else if (in_req_valid == 2'b11) begin
         grant = ~rr_last;
      end
      accept        = (state == IDLE) && !in_rst && (in_req_valid != 2'b00);
      out_req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
      sel_op        = grant ? in_req_op[7:4] : in_req_op[3:0];
      case (sel_op)
         4'b0000, 4'b0001: load_cnt = CNT_W'(ARITH_LAT - 1);
         4'b0010:          load_cnt = CNT_W'(DIV_LAT - 1);
         default:          load_cnt = '0;
      endcase
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state          <= IDLE;
         cnt            <= '0;
         rr_last        <= 1'b1;
         out_fpu_op     <= '0;
         out_fpu_fmt    <= '0;
         out_fpu_addsub <= 1'b0;
         out_fpu_ctrl   <= '0;
         out_fpu_rs1    <= '0;
         out_fpu_rs2    <= '0;
         out_rsp_valid  <= 1'b0;
         out_rsp_id     <= 1'b0;
         out_rsp_data   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  out_fpu_op     <= sel_op;
                  out_fpu_fmt    <= grant ? in_req_fmt[3:2] : in_req_fmt[1:0];
                  out_fpu_addsub <= grant ? in_req_addsub[1] : in_req_addsub[0];
                  out_fpu_ctrl   <= grant ? in_req_ctrl[5:3] : in_req_ctrl[2:0];
                  out_fpu_rs1    <= grant ? in_req_rs1[2*DATA_WIDTH-1:DATA_WIDTH]
                                          : in_req_rs1[DATA_WIDTH-1:0];
                  out_fpu_rs2    <= grant ? in_req_rs2[2*DATA_WIDTH-1:DATA_WIDTH]
                                          : in_req_rs2[DATA_WIDTH-1:0];
                  out_rsp_id     <= grant;
                  rr_last        <= grant;
                  cnt            <= load_cnt;
                  state          <= EXEC;
               end
            end
            EXEC: begin
               // The FPU result is only trusted after its inputs have been held for the full latency.
               if (cnt == '0) begin
                  out_rsp_data  <= in_fpu_result;
                  out_rsp_valid <= 1'b1;
                  state         <= RESP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP: begin
               if (in_rsp_ready) begin
                  out_rsp_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
